banco_registradores: RTL and testbench
======================================

# banco_registradores

32 × 32-bit MIPS register bank: the consumer of the 5-bit destination index produced by the write-register select mux, and the source of both operand reads. Writes are synchronous. Reads are combinational, with a same-cycle write bypass. A sequential dump engine streams all 32 registers, one per cycle, to the test/debug side via a start/valid/done handshake. Sits between the control-driven write-back path and the A/B operand registers of the multicycle datapath.

## Interface
Parameters:
- SP_RESET, 32'd227, reset value of $29 (stack pointer)
- RA_RESET, 32'd0, reset value of $31

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk
- reg_write  in  1  write enable for this cycle
- write_reg  in  5  destination index (from write-register mux)
- write_data  in  32  data to write
- read_reg_1  in  5  read port 1 index (rs)
- read_reg_2  in  5  read port 2 index (rt)
- read_data_1  out  32  read port 1 data, combinational
- read_data_2  out  32  read port 2 data, combinational
- dump_start  in  1  request full-bank dump; level sampled each edge
- dump_busy  out  1  dump engine not IDLE
- dump_valid  out  1  dump_index/dump_data valid this cycle
- dump_index  out  5  register index being presented
- dump_data  out  32  contents of register dump_index
- dump_done  out  1  one-cycle pulse after last word

## Operation
- Storage: reg[0..31], 32 bits each.
- Write: at an edge with reg_write=1 and write_reg≠0, reg[write_reg] ← write_data. Writes to index 0 are discarded; reg[0] is constant 0.
- Read port n:
  - index 0 → 0.
  - Otherwise, if reg_write=1 and write_reg equals the index → write_data (bypass).
  - Otherwise → reg[index].
  - The two ports are independent; both may bypass in the same cycle.
- Reset (edge with reset=1):
  - All registers ← 0, except reg[29] ← SP_RESET and reg[31] ← RA_RESET.
  - Dump FSM → IDLE; dump_busy, dump_valid, dump_done ← 0; dump_index ← 0; dump_data ← 0.
  - reset has priority over reg_write and dump_start in the same cycle.
- Dump FSM states:
  - IDLE: dump_start=1 → DUMP, counter ← 0, dump_busy ← 1.
  - DUMP: each edge, dump_valid ← 1, dump_index ← counter, dump_data ← reg[counter] (pre-edge value; a write on the same edge is not reflected), counter ← counter+1. When counter=31 → DONE.
  - DONE: dump_valid ← 0, dump_done ← 1, dump_busy ← 0 → IDLE.
  - In any state other than DONE, dump_done ← 0 each edge.
- dump_start while busy (DUMP/DONE) is ignored, not queued. dump_start held high continuously restarts a new dump on the first edge after returning to IDLE.
- Normal writes and reads continue unaffected during a dump.
- Reset mid-dump aborts immediately: no dump_done pulse.

## Timing
- All outputs are registered except read_data_1/2, which are combinational from the read indices, reg_write, write_reg, write_data and the array.
- Write latency: the value is visible from the array one edge after write; it is visible on read ports in the same cycle via the bypass.
- Dump, with dump_start sampled at edge E:
  - dump_busy=1 after E.
  - dump_valid=1 after E+1 … E+32 (indices 0…31, consecutive, no gaps).
  - dump_done=1 and dump_busy=0 after E+33, for exactly one cycle.
  - Earliest next start edge: E+34.
- Counter is 5 bits; the transition to DONE is decided at counter=31, so the wrap to 0 is never presented.

## Test plan
- Reset then read all indices → 0 everywhere, except index 29 = 227 and index 31 = 0; all dump outputs = 0.
- reg_write=1, write_reg=8, write_data=0xDEADBEEF, read_reg_1=8 in the same cycle → read_data_1=0xDEADBEEF before the edge. After the edge with reg_write=0 → still 0xDEADBEEF.
- Write 0x12345678 to index 0, then read index 0 on both ports → 0. A dump shows index 0 = 0.
- Write reg[k]=k+0x100 for k=1..31, then pulse dump_start → 32 consecutive valid cycles with index k, data k+0x100 (index 0 → 0), then dump_done for 1 cycle with busy falling. A second dump_start during the dump is ignored.
- During a dump, write reg[5]=0xAAAA at the same edge that presents index 5 → dump shows the old value. A subsequent dump shows 0xAAAA.
- Assert reset at dump index 10 → valid, busy and done go to 0 at the next edge; no done pulse; reg[29]=227 restored.

Source files
------------

// File: rtl/banco_registradores.sv
// banco_registradores: 32 x 32-bit MIPS register bank.
// Synchronous writes, combinational reads with same-cycle write bypass,
// and a sequential dump engine that streams all registers one per cycle.
module banco_registradores #(
    parameter logic [31:0] SP_RESET = 32'd227,
    parameter logic [31:0] RA_RESET = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_write,
    input  logic [4:0]  write_reg,
    input  logic [31:0] write_data,
    input  logic [4:0]  read_reg_1,
    input  logic [4:0]  read_reg_2,
    output logic [31:0] read_data_1,
    output logic [31:0] read_data_2,
    input  logic        dump_start,
    output logic        dump_busy,
    output logic        dump_valid,
    output logic [4:0]  dump_index,
    output logic [31:0] dump_data,
    output logic        dump_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DUMP = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [31:0] regs [32];
    logic [1:0]  state;
    logic [4:0]  counter;

    // Register array: reset loads $29/$31 defaults; index 0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            regs[29] <= SP_RESET;
            regs[31] <= RA_RESET;
        end else if (reg_write && (write_reg != 5'd0)) begin
            regs[write_reg] <= write_data;
        end
    end

    // Read ports: $0 is hard zero, then same-cycle bypass, then array.
    always_comb begin
        read_data_1 = regs[read_reg_1];
        read_data_2 = regs[read_reg_2];
        if (read_reg_1 == 5'd0) begin
            read_data_1 = '0;
        end else if (reg_write && (write_reg == read_reg_1)) begin
            read_data_1 = write_data;
        end
        if (read_reg_2 == 5'd0) begin
            read_data_2 = '0;
        end else if (reg_write && (write_reg == read_reg_2)) begin
            read_data_2 = write_data;
        end
    end

    // Dump engine: IDLE -> DUMP (32 words, pre-edge array contents) -> DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            counter    <= '0;
            dump_busy  <= 1'b0;
            dump_valid <= 1'b0;
            dump_done  <= 1'b0;
            dump_index <= '0;
            dump_data  <= '0;
        end else begin
            dump_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dump_start) begin
                        state     <= ST_DUMP;
                        counter   <= '0;
                        dump_busy <= 1'b1;
                    end
                end
                ST_DUMP: begin
                    dump_valid <= 1'b1;
                    dump_index <= counter;
                    dump_data  <= regs[counter];
                    counter    <= counter + 5'd1;
                    if (counter == 5'd31) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    dump_valid <= 1'b0;
                    dump_done  <= 1'b1;
                    dump_busy  <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    state      <= ST_IDLE;
                    dump_busy  <= 1'b0;
                    dump_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_banco_registradores.sv
// Self-checking bench for banco_registradores: an array model of the bank
// is updated at each clock edge and used to predict reads and dump words.
module tb_banco_registradores;

    localparam logic [31:0] SP = 32'd227;
    localparam logic [31:0] RA = 32'd0;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg_1;
    logic [4:0]  read_reg_2;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic        dump_start;
    logic        dump_busy;
    logic        dump_valid;
    logic [4:0]  dump_index;
    logic [31:0] dump_data;
    logic        dump_done;

    logic [31:0] model [32];
    int tests;
    int fails;

    banco_registradores #(
        .SP_RESET(SP),
        .RA_RESET(RA)
    ) dut (
        .clk(clk),
        .reset(reset),
        .reg_write(reg_write),
        .write_reg(write_reg),
        .write_data(write_data),
        .read_reg_1(read_reg_1),
        .read_reg_2(read_reg_2),
        .read_data_1(read_data_1),
        .read_data_2(read_data_2),
        .dump_start(dump_start),
        .dump_busy(dump_busy),
        .dump_valid(dump_valid),
        .dump_index(dump_index),
        .dump_data(dump_data),
        .dump_done(dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; the model absorbs whatever the inputs requested.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
            model[29] = SP;
            model[31] = RA;
        end else if (reg_write && write_reg != 5'd0) begin
            model[write_reg] = write_data;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        reg_write = 1'b0;
        for (int i = 0; i < 32; i++) begin
            logic [31:0] exp;
            exp = (i == 29) ? 32'd227 : 32'd0;
            read_reg_1 = 5'(i);
            read_reg_2 = 5'(31 - i);
            #1;
            tests++;
            if (read_data_1 !== exp) begin
                fails++;
                $display("FAIL reset_read idx=%0d got=%h exp=%h", i, read_data_1, exp);
            end
        end
        tests++;
        if ({dump_busy, dump_valid, dump_done, dump_index, dump_data} !== 40'd0) begin
            fails++;
            $display("FAIL reset_dump_outs got busy=%b valid=%b done=%b idx=%0d data=%h exp all 0",
                     dump_busy, dump_valid, dump_done, dump_index, dump_data);
        end
    endtask

    task automatic test_bypass();
        reg_write = 1'b1; write_reg = 5'd8; write_data = 32'hDEADBEEF;
        read_reg_1 = 5'd8; read_reg_2 = 5'd8;
        #1;
        tests++;
        if (read_data_1 !== 32'hDEADBEEF || read_data_2 !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL bypass got=%h/%h exp=deadbeef", read_data_1, read_data_2);
        end
        step();
        reg_write = 1'b0;
        #1;
        tests++;
        if (read_data_1 !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL after_write got=%h exp=deadbeef", read_data_1);
        end
    endtask

    task automatic test_zero();
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h12345678;
        read_reg_1 = 5'd0; read_reg_2 = 5'd0;
        #1;
        tests++;
        if (read_data_1 !== 32'd0 || read_data_2 !== 32'd0) begin
            fails++;
            $display("FAIL zero_bypass got=%h/%h exp=0", read_data_1, read_data_2);
        end
        step();
        reg_write = 1'b0;
        #1;
        tests++;
        if (read_data_1 !== 32'd0 || read_data_2 !== 32'd0) begin
            fails++;
            $display("FAIL zero_read got=%h/%h exp=0", read_data_1, read_data_2);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            logic [31:0] e1, e2;
            reg_write  = 1'($urandom_range(0, 1));
            write_reg  = 5'($urandom_range(0, 31));
            write_data = $urandom;
            read_reg_1 = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            read_reg_2 = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            e1 = (read_reg_1 == 0) ? 32'd0 :
                 (reg_write && write_reg == read_reg_1) ? write_data : model[read_reg_1];
            e2 = (read_reg_2 == 0) ? 32'd0 :
                 (reg_write && write_reg == read_reg_2) ? write_data : model[read_reg_2];
            #1;
            tests++;
            if (read_data_1 !== e1 || read_data_2 !== e2) begin
                fails++;
                $display("FAIL random_read n=%0d r1=%0d got=%h exp=%h r2=%0d got=%h exp=%h",
                         n, read_reg_1, read_data_1, e1, read_reg_2, read_data_2, e2);
            end
            step();
        end
        reg_write = 1'b0;
    endtask

    task automatic test_dump();
        for (int k = 1; k < 32; k++) begin
            reg_write = 1'b1; write_reg = 5'(k); write_data = 32'(k) + 32'h100;
            step();
        end
        reg_write = 1'b0;
        dump_start = 1'b1;
        step();
        tests++;
        if (dump_busy !== 1'b1 || dump_valid !== 1'b0) begin
            fails++;
            $display("FAIL dump_begin busy=%b valid=%b exp busy=1 valid=0", dump_busy, dump_valid);
        end
        dump_start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            logic [31:0] exp;
            exp = model[k];
            dump_start = (k >= 3 && k < 8);
            step();
            tests++;
            if (dump_valid !== 1'b1 || dump_busy !== 1'b1 || dump_done !== 1'b0 ||
                dump_index !== 5'(k) || dump_data !== exp) begin
                fails++;
                $display("FAIL dump_word k=%0d got v=%b b=%b d=%b idx=%0d data=%h exp v=1 b=1 d=0 idx=%0d data=%h",
                         k, dump_valid, dump_busy, dump_done, dump_index, dump_data, k, exp);
            end
        end
        dump_start = 1'b0;
        step();
        tests++;
        if (dump_done !== 1'b1 || dump_busy !== 1'b0 || dump_valid !== 1'b0) begin
            fails++;
            $display("FAIL dump_done got d=%b b=%b v=%b exp d=1 b=0 v=0", dump_done, dump_busy, dump_valid);
        end
        step();
        tests++;
        if (dump_done !== 1'b0 || dump_busy !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse_width got d=%b b=%b exp d=0 b=0", dump_done, dump_busy);
        end
    endtask

    task automatic test_dump_write();
        for (int pass = 0; pass < 2; pass++) begin
            dump_start = 1'b1;
            step();
            dump_start = 1'b0;
            for (int k = 0; k < 32; k++) begin
                logic [31:0] exp;
                exp = model[k];
                if (pass == 0 && k == 5) begin
                    reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hAAAA;
                end
                step();
                reg_write = 1'b0;
                if (k == 5) begin
                    tests++;
                    if (dump_index !== 5'd5 || dump_data !== exp) begin
                        fails++;
                        $display("FAIL dump_write pass=%0d idx=%0d data=%h exp idx=5 data=%h",
                                 pass, dump_index, dump_data, exp);
                    end
                end
            end
            step();
            tests++;
            if (dump_done !== 1'b1) begin
                fails++;
                $display("FAIL dump_write_done pass=%0d got=%b exp=1", pass, dump_done);
            end
            step();
        end
        tests++;
        if (model[5] !== 32'hAAAA) begin
            fails++;
            $display("FAIL model_reg5 got=%h exp=0000aaaa", model[5]);
        end
    endtask

    task automatic test_reset_mid_dump();
        int seen_done;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        for (int k = 0; k <= 10; k++) step();
        tests++;
        if (dump_index !== 5'd10 || dump_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_dump_pos idx=%0d v=%b exp idx=10 v=1", dump_index, dump_valid);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++;
        if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0 ||
            dump_index !== 5'd0 || dump_data !== 32'd0) begin
            fails++;
            $display("FAIL abort got v=%b b=%b d=%b idx=%0d data=%h exp all 0",
                     dump_valid, dump_busy, dump_done, dump_index, dump_data);
        end
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (dump_done !== 1'b0 || dump_busy !== 1'b0) seen_done++;
        end
        tests++;
        if (seen_done != 0) begin
            fails++;
            $display("FAIL abort_quiet got=%0d active cycles exp=0", seen_done);
        end
        read_reg_1 = 5'd29;
        read_reg_2 = 5'd8;
        #1;
        tests++;
        if (read_data_1 !== 32'd227 || read_data_2 !== 32'd0) begin
            fails++;
            $display("FAIL reset_restore r29=%h r8=%h exp 000000e3/0", read_data_1, read_data_2);
        end
    endtask

    task automatic test_back_to_back();
        dump_start = 1'b1;
        step();
        for (int k = 0; k < 32; k++) step();
        step();
        tests++;
        if (dump_done !== 1'b1 || dump_busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_done got d=%b b=%b exp d=1 b=0", dump_done, dump_busy);
        end
        step();
        tests++;
        if (dump_busy !== 1'b1 || dump_valid !== 1'b0 || dump_done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_restart got b=%b v=%b d=%b exp b=1 v=0 d=0", dump_busy, dump_valid, dump_done);
        end
        dump_start = 1'b0;
        step();
        tests++;
        if (dump_valid !== 1'b1 || dump_index !== 5'd0 || dump_data !== 32'd0) begin
            fails++;
            $display("FAIL b2b_first got v=%b idx=%0d data=%h exp v=1 idx=0 data=0",
                     dump_valid, dump_index, dump_data);
        end
        for (int k = 1; k < 33; k++) step();
        tests++;
        if (dump_done !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second_done got=%b exp=1", dump_done);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0; reg_write = 1'b0; write_reg = '0; write_data = '0;
        read_reg_1 = '0; read_reg_2 = '0; dump_start = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        test_reset();
        test_bypass();
        test_zero();
        test_random();
        test_dump();
        test_dump_write();
        test_reset_mid_dump();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
